// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames a byte from an external serializer into
// start / data / optional parity / stop bits, with a DATA-state watchdog.
module uart_tx_ctrl #(
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned WDOG_MAX  = 10
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [7:0] P_DATA,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic       ser_data,
  input  logic       ser_done,
  output logic       Load,
  output logic       ser_en,
  output logic       TX_OUT,
  output logic       busy,
  output logic       tx_err
);

  // state  | meaning
  // IDLE   | line high, waiting for Data_Valid (Load issued on accept)
  // START  | start bit (line low), serializer primed
  // DATA   | eight data bits straight from the serializer, watchdog running
  // PARITY | captured parity bit
  // STOP   | STOP_BITS cycles of line high
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [3:0] WDOG_LIM  = 4'(WDOG_MAX);
  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

  state_t     state, state_nxt;
  logic [3:0] wdog;
  logic [1:0] stop_cnt;
  logic       par_en_q;
  logic       par_bit_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= IDLE;
      wdog      <= 4'd0;
      stop_cnt  <= 2'd0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && Data_Valid) begin
        par_en_q  <= PAR_EN;
        par_bit_q <= (^P_DATA) ^ PAR_TYP;
      end
      // Held at zero outside DATA, so it is already clear on entry.
      if (state != DATA)
        wdog <= 4'd0;
      else if (wdog != 4'hF)
        wdog <= wdog + 4'd1;
      if (state != STOP)
        stop_cnt <= 2'd0;
      else
        stop_cnt <= stop_cnt + 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    Load      = 1'b0;
    ser_en    = 1'b0;
    TX_OUT    = 1'b1;
    busy      = 1'b1;
    tx_err    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (Data_Valid) begin
          Load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        TX_OUT    = 1'b0;
        ser_en    = 1'b1;
        state_nxt = DATA;
      end
      DATA: begin
        TX_OUT = ser_data;
        if (ser_done) begin
          state_nxt = par_en_q ? PARITY : STOP;
        end else if (wdog == WDOG_LIM) begin
          tx_err    = 1'b1;
          state_nxt = STOP;
        end else begin
          ser_en = 1'b1;
        end
      end
      PARITY: begin
        TX_OUT    = par_bit_q;
        state_nxt = STOP;
      end
      STOP: begin
        if (stop_cnt == STOP_LAST)
          state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
    // Reset wins over a same-cycle request and suppresses any strobe.
    if (RST) begin
      Load   = 1'b0;
      ser_en = 1'b0;
      tx_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: two instances (1 and 2 stop bits), each
// driving a small serializer model, checked against hand-computed waveforms.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       stuck;

  logic ser_data1, ser_done1, Load1, ser_en1, TX_OUT1, busy1, tx_err1;
  logic ser_data2, ser_done2, Load2, ser_en2, TX_OUT2, busy2, tx_err2;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] c_tx, c_bz, c_ld, c_er, c_en, c2_tx, c2_bz;

  always #5 clk = ~clk;

  uart_tx_ctrl u_dut1 (
    .clk(clk), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data1), .ser_done(ser_done1),
    .Load(Load1), .ser_en(ser_en1), .TX_OUT(TX_OUT1), .busy(busy1), .tx_err(tx_err1)
  );

  uart_tx_ctrl #(.STOP_BITS(2)) u_dut2 (
    .clk(clk), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data2), .ser_done(ser_done2),
    .Load(Load2), .ser_en(ser_en2), .TX_OUT(TX_OUT2), .busy(busy2), .tx_err(tx_err2)
  );

  // Serializer model: bit i appears in the (i+2)th cycle after Load, done on bit 7.
  logic [8:0] sh1, sh2;
  logic [3:0] cnt1, cnt2;

  always_ff @(posedge clk) begin
    if (RST) begin
      sh1 <= '1; cnt1 <= 4'd0;
    end else if (Load1) begin
      sh1 <= {P_DATA, 1'b1}; cnt1 <= 4'd0;
    end else if (ser_en1 && cnt1 != 4'd15) begin
      sh1 <= {1'b0, sh1[8:1]}; cnt1 <= cnt1 + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      sh2 <= '1; cnt2 <= 4'd0;
    end else if (Load2) begin
      sh2 <= {P_DATA, 1'b1}; cnt2 <= 4'd0;
    end else if (ser_en2 && cnt2 != 4'd15) begin
      sh2 <= {1'b0, sh2[8:1]}; cnt2 <= cnt2 + 4'd1;
    end
  end

  assign ser_data1 = sh1[0];
  assign ser_done1 = !stuck && (cnt1 == 4'd8);
  assign ser_data2 = sh2[0];
  assign ser_done2 = (cnt2 == 4'd8);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs n cycles; cycle k uses Data_Valid = dv_mask[k], RST high in cycle rst_at.
  task automatic run(input int n, input logic [7:0] d, input logic pen, input logic ptyp,
                     input logic [31:0] dv_mask, input int rst_at);
    P_DATA  = d;
    PAR_EN  = pen;
    PAR_TYP = ptyp;
    c_tx = '0; c_bz = '0; c_ld = '0; c_er = '0; c_en = '0; c2_tx = '0; c2_bz = '0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      Data_Valid = dv_mask[k];
      RST        = (k == rst_at);
      @(negedge clk);
      c_tx[k]  = TX_OUT1;
      c_bz[k]  = busy1;
      c_ld[k]  = Load1;
      c_er[k]  = tx_err1;
      c_en[k]  = ser_en1;
      c2_tx[k] = TX_OUT2;
      c2_bz[k] = busy2;
    end
    @(posedge clk); #1;
    Data_Valid = 1'b0;
    RST        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    RST = 1'b1; Data_Valid = 1'b1; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; stuck = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx",     32'(TX_OUT1), 32'd1);
    check("rst_busy",   32'(busy1),   32'd0);
    check("rst_load",   32'(Load1),   32'd0);
    check("rst_ser_en", 32'(ser_en1), 32'd0);
    check("rst_tx_err", 32'(tx_err1), 32'd0);
    @(posedge clk); #1;
    RST = 1'b0; Data_Valid = 1'b0;
    idle(3);

    // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1 over cycles 1..11
    run(14, 8'hA5, 1'b1, 1'b0, 32'h1, -1);
    check("a5_tx",     c_tx,  32'h3A95);
    check("a5_busy",   c_bz,  32'h0FFE);
    check("a5_load",   c_ld,  32'h0001);
    check("a5_tx_err", c_er,  32'h0);
    check("a5_ser_en", c_en,  32'h01FE);
    check("a5_busy_s2", c2_bz, 32'h1FFE);
    idle(6);

    // 0x00 odd parity: parity cycle (10) is 1
    run(14, 8'h00, 1'b1, 1'b1, 32'h1, -1);
    check("odd_par_bit", 32'(c_tx[10]), 32'd1);
    check("odd_tx",      c_tx, 32'h3C01);
    idle(6);

    // 0xFF no parity: one or two stop bits
    run(14, 8'hFF, 1'b0, 1'b0, 32'h1, -1);
    check("ff_tx_s1",   c_tx,  32'h3FFD);
    check("ff_busy_s1", c_bz,  32'h07FE);
    check("ff_tx_s2",   c2_tx, 32'h3FFD);
    check("ff_busy_s2", c2_bz, 32'h0FFE);
    idle(6);

    // Held request, then toggling during frame 2: loads at cycles 0 and 12 only
    run(32, 8'hA5, 1'b1, 1'b0, 32'h00555FFF, -1);
    check("b2b_load", c_ld, 32'h00001001);
    check("b2b_busy", c_bz, 32'h00FFEFFE);
    idle(6);

    // Stuck serializer: 10 DATA cycles, error in the 11th, then STOP (parity skipped)
    stuck = 1'b1;
    run(16, 8'h3C, 1'b1, 1'b0, 32'h1, -1);
    check("wd_tx_err",  c_er, 32'h1000);
    check("wd_busy",    c_bz, 32'h3FFE);
    check("wd_ser_en",  c_en, 32'h0FFE);
    check("wd_stop_tx", 32'(c_tx[13]), 32'd1);
    stuck = 1'b0;
    idle(6);

    // Reset in 4th DATA cycle (cycle 5) aborts the frame
    run(10, 8'hA5, 1'b1, 1'b0, 32'h1, 5);
    check("abort_tx",     32'(c_tx[6]), 32'd1);
    check("abort_busy",   c_bz, 32'h003E);
    check("abort_ser_en", 32'(c_en[6]), 32'd0);
    check("abort_tx_err", c_er, 32'h0);
    idle(2);
    run(14, 8'hA5, 1'b1, 1'b0, 32'h1, -1);
    check("post_rst_tx", c_tx, 32'h3A95);
    idle(6);

    // Reset and request together: reset wins, request taken the next cycle
    run(3, 8'h5A, 1'b0, 1'b0, 32'h7, 0);
    check("rst_prio_load", c_ld, 32'h2);
    check("rst_prio_busy", c_bz, 32'h4);
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
